// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline register: default widths,
// payload field map for the five-stage CPU bundle, and occupancy encodings.
package pipe_pkg;

  localparam int unsigned TNEW_W_DEF = 2;
  localparam int unsigned PAYLOAD_W_DEF = 128;

  // Payload field map (LSB offsets and widths) of the 128-bit stage bundle
  localparam int unsigned PC_OFF = 0;
  localparam int unsigned PC_W = 16;
  localparam int unsigned INSTR_OFF = PC_OFF + PC_W;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ALUOUT_OFF = INSTR_OFF + INSTR_W;
  localparam int unsigned ALUOUT_W = 32;
  localparam int unsigned R2_OFF = ALUOUT_OFF + ALUOUT_W;
  localparam int unsigned R2_W = 32;
  localparam int unsigned IMM_OFF = R2_OFF + R2_W;
  localparam int unsigned IMM_W = 6;
  localparam int unsigned RD_OFF = IMM_OFF + IMM_W;
  localparam int unsigned RD_W = 5;
  localparam int unsigned RT_OFF = RD_OFF + RD_W;
  localparam int unsigned RT_W = 5;

  // Same map as a packed struct, MSB field first
  typedef struct packed {
    logic [RT_W-1:0]     rt;
    logic [RD_W-1:0]     rd;
    logic [IMM_W-1:0]    imm;
    logic [R2_W-1:0]     r2;
    logic [ALUOUT_W-1:0] aluout;
    logic [INSTR_W-1:0]  instr;
    logic [PC_W-1:0]     pc;
  } stage_payload_t;

  // Number of valid entries held by the stage
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/pipe_entry.sv
// One register slot {valid, payload, tnew} with load / clear / hold control.
// Clear drops valid and tnew; the payload is kept unless zero_payload is set.
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int unsigned PAYLOAD_W = PAYLOAD_W_DEF,
  parameter int unsigned TNEW_W    = TNEW_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 clear,
  input  logic                 zero_payload,
  input  logic [PAYLOAD_W-1:0] d_payload,
  input  logic [TNEW_W-1:0]    d_tnew,
  output logic                 valid,
  output logic [PAYLOAD_W-1:0] payload,
  output logic [TNEW_W-1:0]    tnew
);

  // Slot register; load wins over clear
  always_ff @(posedge clk) begin
    if (reset) begin
      valid   <= 1'b0;
      payload <= '0;
      tnew    <= '0;
    end else if (load) begin
      valid   <= 1'b1;
      payload <= d_payload;
      tnew    <= d_tnew;
    end else if (clear) begin
      valid <= 1'b0;
      tnew  <= '0;
      if (zero_payload) begin
        payload <= '0;
      end
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready handshake, a
// two-entry skid buffer (main + skid) and flush. Optional performance
// counters are enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned PAYLOAD_W      = PAYLOAD_W_DEF,
  parameter int unsigned TNEW_W         = TNEW_W_DEF,
  parameter int unsigned TNEW_DEC       = 1,
  parameter bit          CLEAR_ON_FLUSH = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic [TNEW_W-1:0]    in_tnew,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [TNEW_W-1:0]    out_tnew,
  output logic [1:0]           occupancy
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]          perf_stall_cnt,
  output logic [31:0]          perf_bubble_cnt
`endif
);

  occ_e occ_q, occ_d;

  logic                 main_valid, skid_valid;
  logic [PAYLOAD_W-1:0] main_payload, skid_payload, main_d_payload;
  logic [TNEW_W-1:0]    main_tnew, skid_tnew, main_d_tnew, in_tnew_dec;

  logic accept, consume;
  logic main_load, main_from_skid, main_clear;
  logic skid_load, skid_clear, zero_pl;

  assign accept  = in_valid & ~skid_valid & ~flush;
  assign consume = main_valid & out_ready;

  // Saturating Tnew decrement applied once on entry
  always_comb begin
    in_tnew_dec = '0;
    if (32'(in_tnew) > TNEW_DEC) begin
      in_tnew_dec = in_tnew - TNEW_W'(TNEW_DEC);
    end
  end

  // Occupancy state register
  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q <= EMPTY;
    end else begin
      occ_q <= occ_d;
    end
  end

  // Next occupancy and slot controls; flush overrides any accept/consume
  always_comb begin
    occ_d          = occ_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    main_clear     = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    zero_pl        = 1'b0;
    if (flush) begin
      occ_d      = EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
      zero_pl    = CLEAR_ON_FLUSH;
    end else begin
      case (occ_q)
        EMPTY: begin
          if (accept) begin
            main_load = 1'b1;
            occ_d     = ONE;
          end
        end
        ONE: begin
          if (accept && consume) begin
            main_load = 1'b1;
          end else if (accept) begin
            skid_load = 1'b1;
            occ_d     = FULL;
          end else if (consume) begin
            main_clear = 1'b1;
            occ_d      = EMPTY;
          end
        end
        FULL: begin
          if (consume) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
            occ_d          = ONE;
          end
        end
        default: begin
          occ_d = EMPTY;
        end
      endcase
    end
  end

  // Main slot is refilled from skid first to keep FIFO order
  always_comb begin
    main_d_payload = in_payload;
    main_d_tnew    = in_tnew_dec;
    if (main_from_skid) begin
      main_d_payload = skid_payload;
      main_d_tnew    = skid_tnew;
    end
  end

  pipe_entry #(
    .PAYLOAD_W (PAYLOAD_W),
    .TNEW_W    (TNEW_W)
  ) u_main (
    .clk          (clk),
    .reset        (reset),
    .load         (main_load),
    .clear        (main_clear),
    .zero_payload (zero_pl),
    .d_payload    (main_d_payload),
    .d_tnew       (main_d_tnew),
    .valid        (main_valid),
    .payload      (main_payload),
    .tnew         (main_tnew)
  );

  pipe_entry #(
    .PAYLOAD_W (PAYLOAD_W),
    .TNEW_W    (TNEW_W)
  ) u_skid (
    .clk          (clk),
    .reset        (reset),
    .load         (skid_load),
    .clear        (skid_clear),
    .zero_payload (zero_pl),
    .d_payload    (in_payload),
    .d_tnew       (in_tnew_dec),
    .valid        (skid_valid),
    .payload      (skid_payload),
    .tnew         (skid_tnew)
  );

  assign in_ready    = ~skid_valid;
  assign out_valid   = main_valid;
  assign out_payload = main_payload;
  assign out_tnew    = main_tnew;
  assign occupancy   = occ_q;

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_q, bubble_q, bubble_add;

  assign bubble_add = 32'(~main_valid) + 32'(flush & (main_valid | skid_valid));

  // Saturating stall and bubble counters
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (main_valid && !out_ready && (stall_q != 32'hFFFF_FFFF)) begin
        stall_q <= stall_q + 32'd1;
      end
      if (bubble_q > (32'hFFFF_FFFF - bubble_add)) begin
        bubble_q <= 32'hFFFF_FFFF;
      end else begin
        bubble_q <= bubble_q + bubble_add;
      end
    end
  end

  assign perf_stall_cnt  = stall_q;
  assign perf_bubble_cnt = bubble_q;
`else
  // No performance counters in this build
`endif

endmodule
